// File: rtl/wb_host_bridge_pkg.sv
// Shared definitions for the Wishbone host bridge: bus widths, the
// error data pattern, the bridge state enum and the latched request.
package emu_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = WB_DAT_W / 8;

    // Read data returned when a transaction is abandoned for lack of ack.
    localparam logic [WB_DAT_W-1:0] WB_ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } bridge_state_e;

    // One host command as held on the Wishbone side.
    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_req_t;

endpackage

// File: rtl/wb_host_bridge_if.sv
// Host command/response channel plus Wishbone classic initiator signals.
// The bridge takes the master view; the host/responder side takes slave.
interface wb_host_bridge_if;
    import emu_wb_pkg::*;

    // host command channel
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic                cmd_we_i;
    logic [WB_ADR_W-1:0] cmd_adr_i;
    logic [WB_DAT_W-1:0] cmd_dat_i;
    logic [WB_SEL_W-1:0] cmd_sel_i;

    // host response channel
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [WB_DAT_W-1:0] rsp_dat_o;
    logic                rsp_err_o;

    // Wishbone classic initiator
    logic                wbm_cyc_o;
    logic                wbm_stb_o;
    logic                wbm_we_o;
    logic [WB_SEL_W-1:0] wbm_sel_o;
    logic [WB_ADR_W-1:0] wbm_adr_o;
    logic [WB_DAT_W-1:0] wbm_dat_o;
    logic                wbm_ack_i;
    logic [WB_DAT_W-1:0] wbm_dat_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );

endinterface

// File: rtl/wb_host_bridge.sv
// Host-to-Wishbone bridge: accepts one command at a time, runs a classic
// Wishbone cycle, and returns read data (or an error pattern on timeout)
// on a valid/ready response channel. All outputs are registered.
module wb_host_bridge
    import emu_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    wb_host_bridge_if.master bus
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    bridge_state_e       r_state;
    logic                r_cmd_ready;
    wb_req_t             r_req;
    logic                r_cyc;
    logic                r_rsp_valid;
    logic [WB_DAT_W-1:0] r_rsp_dat;
    logic                r_rsp_err;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_accept;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_timeout;

    assign w_accept  = r_cmd_ready & bus.cmd_valid_i;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // The current ack-less cycle is the one that makes the count hit the limit.
    assign w_timeout = (w_cnt_inc == CNT_LIMIT);

    // Bridge FSM: command latch, bus cycle with timeout, response hold.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_req       <= '0;
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req.we    <= bus.cmd_we_i;
                        r_req.adr   <= bus.cmd_adr_i;
                        r_req.dat   <= bus.cmd_dat_i;
                        r_req.sel   <= bus.cmd_sel_i;
                        r_cyc       <= 1'b1;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (bus.wbm_ack_i) begin
                        r_rsp_dat   <= r_req.we ? '0 : bus.wbm_dat_i;
                        r_rsp_err   <= 1'b0;
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_timeout) begin
                        r_cnt       <= w_cnt_inc;
                        r_rsp_dat   <= WB_ERR_DATA;
                        r_rsp_err   <= 1'b1;
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                RESP: begin
                    // Ready rises one cycle after the handoff, so no command
                    // can slip in on the same edge the response is consumed.
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_cyc       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o = r_cmd_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_dat_o   = r_rsp_dat;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.wbm_cyc_o   = r_cyc;
    assign bus.wbm_stb_o   = r_cyc;
    assign bus.wbm_we_o    = r_req.we;
    assign bus.wbm_sel_o   = r_req.sel;
    assign bus.wbm_adr_o   = r_req.adr;
    assign bus.wbm_dat_o   = r_req.dat;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed bench for wb_host_bridge with a transaction-level reference
// model and per-cycle comparison, plus literal pins on key cycles.
module tb_wb_host_bridge;

    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wb_host_bridge_if bif ();

    wb_host_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Tracks the single outstanding transaction: whether it is on the bus,
    // how many bus cycles it has spent without ack, and the pending response.
    logic        m_bus  = 1'b0;
    logic        m_rsp  = 1'b0;
    int          m_wait = 0;
    logic        m_we   = 1'b0;
    logic [31:0] m_adr  = '0;
    logic [31:0] m_dat  = '0;
    logic [3:0]  m_sel  = '0;
    logic [31:0] m_rd   = '0;
    logic        m_re   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bus <= 1'b0; m_rsp <= 1'b0; m_wait <= 0;
            m_we <= 1'b0; m_adr <= '0; m_dat <= '0; m_sel <= '0;
            m_rd <= '0; m_re <= 1'b0;
        end else if (m_bus) begin
            if (bif.wbm_ack_i) begin
                m_bus <= 1'b0; m_rsp <= 1'b1;
                m_rd  <= m_we ? 32'h0 : bif.wbm_dat_i;
                m_re  <= 1'b0;
            end else if (m_wait + 1 == TO) begin
                m_bus <= 1'b0; m_rsp <= 1'b1;
                m_rd  <= 32'hFFFF_FFFF;
                m_re  <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (m_rsp) begin
            if (bif.rsp_ready_i) m_rsp <= 1'b0;
        end else if (bif.cmd_valid_i) begin
            m_bus <= 1'b1; m_wait <= 0;
            m_we <= bif.cmd_we_i; m_adr <= bif.cmd_adr_i;
            m_dat <= bif.cmd_dat_i; m_sel <= bif.cmd_sel_i;
        end
    end

    // ---------------- literal pins (set by stimulus) ----------------
    bit          pin_cyc_en = 0;
    bit          pin_cyc    = 0;
    bit          pin_rsp_en = 0;
    bit          pin_rv     = 0;
    logic [31:0] pin_rd     = '0;
    bit          pin_re     = 0;
    bit          pin_rdy_en = 0;
    bit          pin_rdy    = 0;
    bit          pin_req_en = 0;
    bit          pin_we     = 0;
    logic [31:0] pin_adr    = '0;
    logic [31:0] pin_dat    = '0;
    logic [3:0]  pin_sel    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        chk("cmd_ready", 32'(bif.cmd_ready_o), 32'(!(m_bus || m_rsp)));
        chk("cyc",       32'(bif.wbm_cyc_o),   32'(m_bus));
        chk("stb",       32'(bif.wbm_stb_o),   32'(m_bus));
        chk("we",        32'(bif.wbm_we_o),    32'(m_we));
        chk("sel",       32'(bif.wbm_sel_o),   32'(m_sel));
        chk("adr",       bif.wbm_adr_o,        m_adr);
        chk("wdat",      bif.wbm_dat_o,        m_dat);
        chk("rsp_valid", 32'(bif.rsp_valid_o), 32'(m_rsp));
        chk("rsp_dat",   bif.rsp_dat_o,        m_rd);
        chk("rsp_err",   32'(bif.rsp_err_o),   32'(m_re));
        if (pin_cyc_en) begin
            chk("pin_cyc", 32'(bif.wbm_cyc_o), 32'(pin_cyc));
            chk("pin_stb", 32'(bif.wbm_stb_o), 32'(pin_cyc));
        end
        if (pin_rsp_en) begin
            chk("pin_rsp_valid", 32'(bif.rsp_valid_o), 32'(pin_rv));
            chk("pin_rsp_dat",   bif.rsp_dat_o,        pin_rd);
            chk("pin_rsp_err",   32'(bif.rsp_err_o),   32'(pin_re));
        end
        if (pin_rdy_en)
            chk("pin_cmd_ready", 32'(bif.cmd_ready_o), 32'(pin_rdy));
        if (pin_req_en) begin
            chk("pin_we",  32'(bif.wbm_we_o),  32'(pin_we));
            chk("pin_adr", bif.wbm_adr_o,      pin_adr);
            chk("pin_dat", bif.wbm_dat_o,      pin_dat);
            chk("pin_sel", 32'(bif.wbm_sel_o), 32'(pin_sel));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pins();
        pin_cyc_en = 0; pin_rsp_en = 0; pin_rdy_en = 0; pin_req_en = 0;
    endtask

    task automatic p_cyc(input bit c);
        pin_cyc_en = 1; pin_cyc = c;
    endtask

    task automatic p_rsp(input bit rv, input logic [31:0] rd, input bit re);
        pin_rsp_en = 1; pin_rv = rv; pin_rd = rd; pin_re = re;
    endtask

    task automatic p_rdy(input bit r);
        pin_rdy_en = 1; pin_rdy = r;
    endtask

    task automatic p_req(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        pin_req_en = 1; pin_we = we; pin_adr = adr; pin_dat = dat; pin_sel = sel;
    endtask

    task automatic drive_cmd(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bif.cmd_valid_i = 1'b1; bif.cmd_we_i = we;
        bif.cmd_adr_i = adr; bif.cmd_dat_i = dat; bif.cmd_sel_i = sel;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bif.cmd_valid_i = 1'b0; bif.cmd_we_i = 1'b0; bif.cmd_adr_i = '0;
        bif.cmd_dat_i = '0; bif.cmd_sel_i = '0; bif.rsp_ready_i = 1'b0;
        bif.wbm_ack_i = 1'b0; bif.wbm_dat_i = '0;

        // reset state
        p_cyc(0); p_rsp(0, 32'h0, 0); p_rdy(1); p_req(0, 32'h0, 32'h0, 4'h0);
        tick(); tick();
        rst_n = 1'b1; clr_pins();

        // write, ack on third bus cycle, response held one cycle then taken
        drive_cmd(1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        tick();
        bif.cmd_valid_i = 1'b0;
        p_cyc(1); p_rdy(0); p_req(1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        tick(); tick();
        bif.wbm_ack_i = 1'b1; bif.wbm_dat_i = 32'h5555_AAAA;
        tick();
        bif.wbm_ack_i = 1'b0;
        p_cyc(0); p_rsp(1, 32'h0, 0);
        bif.rsp_ready_i = 1'b1;
        tick();
        clr_pins(); p_cyc(0); p_rsp(0, 32'h0, 0); p_rdy(1);

        // read, ack on first bus cycle: response during cycle N+2
        drive_cmd(0, 32'h3000_0000, 32'h0, 4'hF);
        tick();
        clr_pins();
        bif.cmd_valid_i = 1'b0;
        bif.wbm_ack_i = 1'b1; bif.wbm_dat_i = 32'hCAFE_F00D;
        p_cyc(1); p_req(0, 32'h3000_0000, 32'h0, 4'hF);
        tick();
        bif.wbm_ack_i = 1'b0; bif.wbm_dat_i = '0;
        p_cyc(0); p_rsp(1, 32'hCAFE_F00D, 0);
        tick();
        p_rsp(0, 32'hCAFE_F00D, 0); p_rdy(1);

        // read with no ack: timeout after TO bus cycles
        drive_cmd(0, 32'h3000_0008, 32'h0, 4'h1);
        tick();
        clr_pins();
        bif.cmd_valid_i = 1'b0;
        for (int i = 0; i < TO; i++) begin
            p_cyc(1);
            tick();
        end
        p_cyc(0); p_rsp(1, 32'hFFFF_FFFF, 1);
        tick();
        p_rsp(0, 32'hFFFF_FFFF, 1); p_rdy(1);

        // read with ack on the exact timeout cycle: ack wins
        drive_cmd(0, 32'h3000_000C, 32'h0, 4'hF);
        tick();
        clr_pins();
        bif.cmd_valid_i = 1'b0;
        for (int i = 0; i < TO; i++) begin
            p_cyc(1);
            if (i == TO - 1) begin
                bif.wbm_ack_i = 1'b1; bif.wbm_dat_i = 32'h1234_5678;
            end
            tick();
        end
        bif.wbm_ack_i = 1'b0;
        p_cyc(0); p_rsp(1, 32'h1234_5678, 0);
        tick();

        // stray ack while idle: nothing moves
        bif.wbm_ack_i = 1'b1; bif.wbm_dat_i = 32'hDEAD_BEEF;
        p_cyc(0); p_rsp(0, 32'h1234_5678, 0); p_rdy(1);
        tick(); tick();
        bif.wbm_ack_i = 1'b0;
        clr_pins();

        // write, then host stalls the response 10 cycles with a new command
        // waiting and stray acks arriving; response must stay put
        bif.rsp_ready_i = 1'b0;
        drive_cmd(1, 32'h3000_0010, 32'h0BAD_F00D, 4'h3);
        tick();
        bif.wbm_ack_i = 1'b1; bif.wbm_dat_i = 32'hDEAD_BEEF;
        drive_cmd(0, 32'h3000_0020, 32'h0, 4'hC);
        p_cyc(1); p_rdy(0); p_req(1, 32'h3000_0010, 32'h0BAD_F00D, 4'h3);
        tick();
        for (int i = 0; i < 10; i++) begin
            bif.wbm_ack_i = (i % 2 == 1); bif.wbm_dat_i = 32'hFFFF_0000;
            p_cyc(0); p_rsp(1, 32'h0, 0); p_rdy(0);
            tick();
        end
        bif.wbm_ack_i = 1'b0;
        bif.rsp_ready_i = 1'b1;
        tick();
        // response handed off; the waiting command is not taken on that edge
        p_cyc(0); p_rsp(0, 32'h0, 0); p_rdy(1);
        tick();
        bif.cmd_valid_i = 1'b0;
        clr_pins(); p_cyc(1); p_rdy(0); p_req(0, 32'h3000_0020, 32'h0, 4'hC);
        tick();

        // reset in the middle of the bus cycle
        #2;
        rst_n = 1'b0;
        clr_pins(); p_cyc(0); p_rsp(0, 32'h0, 0); p_rdy(1); p_req(0, 32'h0, 32'h0, 4'h0);
        bif.wbm_ack_i = 1'b1; bif.wbm_dat_i = 32'h7777_7777;
        drive_cmd(1, 32'h3000_0030, 32'h1111_2222, 4'h1);
        tick(); tick();
        // release: first edge after release may take the pending command
        rst_n = 1'b1;
        bif.wbm_ack_i = 1'b0;
        clr_pins(); p_rsp(0, 32'h0, 0);
        tick();
        bif.cmd_valid_i = 1'b0;
        p_cyc(1); p_req(1, 32'h3000_0030, 32'h1111_2222, 4'h1);
        bif.wbm_ack_i = 1'b1;
        tick();
        bif.wbm_ack_i = 1'b0;
        p_cyc(0); p_rsp(1, 32'h0, 0);
        tick();
        p_rsp(0, 32'h0, 0); p_rdy(1);
        tick(); tick();
        clr_pins();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_host_bridge.md
WB_HOST_BRIDGE -- requirements
Module: wb_host_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the max cycles to wait for ack before aborting (range 1..65535).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: wb_clk_i  input  1  clock; wb_rst_n_i  input  1  async active-low reset.
REQ-003 cmd_valid_i  input  1  host command present.
REQ-004 cmd_ready_o  output  1  bridge accepts command this cycle.
REQ-005 cmd_we_i  input  1  1=write, 0=read.
REQ-006 cmd_adr_i  input  32  byte address.
REQ-007 cmd_dat_i  input  32  write data.
REQ-008 cmd_sel_i  input  4  byte selects.
REQ-009 rsp_valid_o  output  1  response available.
REQ-010 rsp_ready_i  input  1  host consumes response.
REQ-011 rsp_dat_o  output  32  read data (0 for writes).
REQ-012 rsp_err_o  output  1  transaction timed out.
REQ-013 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic initiator strobes, driven into user_project_wrapper wbs_cyc_i/wbs_stb_i/wbs_we_i.
REQ-014 wbm_sel_o  output  4;  wbm_adr_o  output  32;  wbm_dat_o  output  32  registered request fields.
REQ-015 wbm_ack_i  input  1;  wbm_dat_i  input  32  responder ack and read data.

Function
REQ-016 SHALL implement FSM states IDLE, BUS, RESP.
REQ-017 IDLE: cmd_ready_o=1; on cmd_valid_i&cmd_ready_o SHALL latch we/adr/dat/sel and enter BUS.
REQ-018 In BUS, cyc/stb SHALL be 1 and request fields stable; command accepted at edge N gives cyc/stb high from cycle N+1.
REQ-019 cmd_ready_o SHALL be 0 in BUS and RESP; only one transaction outstanding.
REQ-020 BUS: on wbm_ack_i=1 SHALL capture wbm_dat_i (reads) or 0 (writes) into rsp_dat_o, clear rsp_err_o, drop cyc/stb at the same edge, enter RESP.
REQ-021 BUS: a cycle counter cleared on entry SHALL count cycles without ack; when it reaches TIMEOUT_CYCLES, SHALL drop cyc/stb, set rsp_err_o=1, rsp_dat_o=32'hFFFF_FFFF, enter RESP.
REQ-022 Ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win (normal completion, no error).
REQ-023 RESP: rsp_valid_o=1 with stable data/err until rsp_valid_o&rsp_ready_i, then IDLE; a new command SHALL not be accepted on that same edge (cmd_ready_o rises next cycle).
REQ-024 wbm_ack_i outside BUS SHALL be ignored with no state or output change.
REQ-025 Minimum round trip (ack on first BUS cycle, rsp_ready_i held 1): command accept edge N, rsp_valid_o high during cycle N+2.
REQ-026 wbm_we_o/sel/adr/dat SHALL hold last-latched values when cyc is low.

Reset
REQ-027 On wb_rst_n_i=0, state=IDLE and all outputs SHALL clear asynchronously: cyc/stb/we=0, sel=0, adr=0, dat=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, counter=0; cmd_ready_o=1 once state is IDLE.
REQ-028 Reset asserted mid-BUS SHALL drop cyc/stb immediately; the aborted transaction SHALL produce no response.
REQ-029 Reset deassertion SHALL take effect on the next wb_clk_i rising edge; no command accepted before it.

Structure
REQ-030 Shared package emu_wb_pkg SHALL hold the state enum (IDLE/BUS/RESP), WB_ADR_W=32, WB_DAT_W=32, and WB_ERR_DATA=32'hFFFF_FFFF.
REQ-031 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); no sub-module required.

Verification
REQ-032 Write adr=0x3000_0004 dat=0xA5A5_1234 sel=0xF, ack after 3 cycles -> bus shows we=1 with those values for 3 cycles, rsp_valid with dat=0, err=0.
REQ-033 Read adr=0x3000_0000, ack on first BUS cycle with dat_i=0xCAFE_F00D, rsp_ready_i=1 -> rsp_dat_o=0xCAFE_F00D at cycle N+2, err=0.
REQ-034 TIMEOUT_CYCLES=4, read, no ack -> cyc drops after 4 BUS cycles, rsp_err_o=1, rsp_dat_o=0xFFFF_FFFF.
REQ-035 Ack on the exact timeout cycle -> normal response, err=0; stray ack in IDLE/RESP -> no change.
REQ-036 rsp_ready_i held 0 for 10 cycles with cmd_valid_i=1 -> rsp fields stable, cmd_ready_o=0 throughout; reset asserted mid-BUS -> cyc/stb=0 immediately, no rsp_valid_o afterward.
